pfpu_atan2: RTL

// - PFPU ALU unit: angle = atan2(b, a) from two signed 32-bit integer operands (a = x, b = y).
// - Result uses the angle format pfpu_sincos consumes: 8192 LSB per turn, signed, range [-4096, 4095].
// - Fully pipelined CORDIC in vectoring mode: one op accepted every cycle, fixed latency, no stall.
// - Sits beside the other PFPU ALU units; result muxed onto the PFPU result bus by valid_o.

---
 rtl/pfpu_atan2_pkg.sv | 37 +++
 rtl/pfpu_cordic_stage.sv | 37 +++
 rtl/pfpu_atan2.sv | 90 +++++++++
 3 files changed

// File: rtl/pfpu_atan2_pkg.sv
// pfpu_atan2_pkg: angle widths, CORDIC arctangent table and operand helpers
package pfpu_atan2_pkg;

    localparam int Z_W   = 16;
    localparam int OUT_W = 13;
    localparam int FRAC  = 3;

    function automatic logic signed [Z_W-1:0] atan_tab(input int i);
        case (i)
            0:       return 16'sd8192;
            1:       return 16'sd4836;
            2:       return 16'sd2555;
            3:       return 16'sd1297;
            4:       return 16'sd651;
            5:       return 16'sd326;
            6:       return 16'sd163;
            7:       return 16'sd81;
            8:       return 16'sd41;
            9:       return 16'sd20;
            10:      return 16'sd10;
            11:      return 16'sd5;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [31:0] neg_sat(input logic signed [31:0] v);
        return v == 32'sh8000_0000 ? 32'sh7fff_ffff : -v;
    endfunction

    function automatic logic [4:0] lod32(input logic [31:0] v);
        logic [4:0] p;
        p = '0;
        for (int k = 0; k < 32; k++) if (v[k]) p = 5'(k);
        return p;
    endfunction

endpackage

// File: rtl/pfpu_cordic_stage.sv
// pfpu_cordic_stage: one registered vectoring-mode CORDIC iteration
module pfpu_cordic_stage
    import pfpu_atan2_pkg::*;
#(
    parameter int I = 0,
    parameter int W = 20
) (
    input  logic                  sys_clk,
    input  logic                  alu_rst,
    input  logic signed [W-1:0]   x,
    input  logic signed [W-1:0]   y,
    input  logic signed [Z_W-1:0] z,
    input  logic                  vld,
    input  logic                  zero,
    output logic signed [W-1:0]   x_q,
    output logic signed [W-1:0]   y_q,
    output logic signed [Z_W-1:0] z_q,
    output logic                  vld_q,
    output logic                  zero_q
);

    logic                  d;
    logic signed [Z_W-1:0] t;

    assign d = ~y[W-1];
    assign t = atan_tab(I);

    // rotate the vector toward the x axis and accumulate the angle; only valid is reset
    always_ff @(posedge sys_clk) begin
        vld_q  <= alu_rst ? 1'b0 : vld;
        x_q    <= d ? x + (y >>> I) : x - (y >>> I);
        y_q    <= d ? y - (x >>> I) : y + (x >>> I);
        z_q    <= d ? z + t : z - t;
        zero_q <= zero;
    end

endmodule

// File: rtl/pfpu_atan2.sv
// pfpu_atan2: pipelined CORDIC atan2(b, a), 8192 LSB per turn, latency ITER+3
module pfpu_atan2
    import pfpu_atan2_pkg::*;
#(
    parameter int ITER = 12,
    parameter int W    = 20
) (
    input  logic        sys_clk,
    input  logic        alu_rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        valid_i,
    output logic [31:0] r,
    output logic        valid_o
);

    // top bit of max(|x|,|y|) lands here: the final x reaches gain * sqrt(2) * max
    localparam logic [4:0] NORM = 5'(W - 4);

    logic signed [31:0]    x1, y1;
    logic signed [Z_W-1:0] z1;
    logic                  v1;
    logic [31:0]           ay, m;
    logic [4:0]            p;
    logic signed [W-1:0]   x2, y2;
    logic signed [Z_W-1:0] z2;
    logic                  v2, zero2;
    logic signed [W-1:0]   xp [ITER+1];
    logic signed [W-1:0]   yp [ITER+1];
    logic signed [Z_W-1:0] zp [ITER+1];
    logic                  vp [ITER+1];
    logic                  zf [ITER+1];
    logic signed [OUT_W-1:0] q;

    // fold the left half-plane onto x >= 0; +/-half turn are the same 16-bit code
    always_ff @(posedge sys_clk) begin
        v1 <= alu_rst ? 1'b0 : valid_i;
        x1 <= a[31] ? neg_sat($signed(a)) : $signed(a);
        y1 <= a[31] ? neg_sat($signed(b)) : $signed(b);
        z1 <= a[31] ? 16'sh8000 : 16'sh0000;
    end

    // leading-one position of the larger operand magnitude
    always_comb begin
        ay = y1[31] ? $unsigned(-y1) : $unsigned(y1);
        m  = $unsigned(x1) > ay ? $unsigned(x1) : ay;
        p  = lod32(m);
    end

    // scale both operands by the same power of two; the angle is unaffected
    always_ff @(posedge sys_clk) begin
        v2    <= alu_rst ? 1'b0 : v1;
        x2    <= W'(p > NORM ? x1 >>> (p - NORM) : x1 <<< (NORM - p));
        y2    <= W'(p > NORM ? y1 >>> (p - NORM) : y1 <<< (NORM - p));
        z2    <= z1;
        zero2 <= m == 32'd0;
    end

    assign xp[0] = x2;
    assign yp[0] = y2;
    assign zp[0] = z2;
    assign vp[0] = v2;
    assign zf[0] = zero2;

    for (genvar i = 0; i < ITER; i++) begin : g_stage
        pfpu_cordic_stage #(.I(i), .W(W)) u_stage (
            .sys_clk (sys_clk),
            .alu_rst (alu_rst),
            .x       (xp[i]),
            .y       (yp[i]),
            .z       (zp[i]),
            .vld     (vp[i]),
            .zero    (zf[i]),
            .x_q     (xp[i+1]),
            .y_q     (yp[i+1]),
            .z_q     (zp[i+1]),
            .vld_q   (vp[i+1]),
            .zero_q  (zf[i+1])
        );
    end

    assign q = OUT_W'((zp[ITER] + 16'sd4) >>> FRAC);

    // round away the extra fraction bits; the origin has no angle and reads as zero
    always_ff @(posedge sys_clk) begin
        valid_o <= alu_rst ? 1'b0 : vp[ITER];
        r       <= zf[ITER] ? 32'd0 : {{(32-OUT_W){q[OUT_W-1]}}, q};
    end

endmodule
